sdram_responder: RTL and testbench



---
 rtl/sdram_pkg.sv | 48 ++++
 rtl/sdram_resp_mem.sv | 22 ++
 rtl/sdram_responder.sv | 214 +++++++++++++++++++++
 tb/tb_sdram_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM command-bus definitions used by the controller and the device responder.
package sdram_pkg;

    localparam int DQ_WIDTH = 16;
    localparam int AP_BIT   = 10;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_INIT     = 3'd1,
        ERR_ACT_OPEN = 3'd2,
        ERR_CLOSED   = 3'd3,
        ERR_REF_OPEN = 3'd4,
        ERR_MRS      = 3'd5,
        ERR_TRCD     = 3'd6,
        ERR_TRFC     = 3'd7
    } sdram_err_t;

    typedef enum logic [2:0] {
        W_PALL,
        W_REF1,
        W_REF2,
        W_MRS,
        READY
    } init_state_t;

    localparam int MRS_CL_LSB = 4;
    localparam int MRS_CL_MSB = 6;
    localparam int MRS_BL_MSB = 2;

    localparam logic [2:0] CL_2 = 3'd2;
    localparam logic [2:0] CL_3 = 3'd3;

    function automatic logic cl_legal(input logic [2:0] cl);
        return (cl == CL_2) || (cl == CL_3);
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port backing store for the SDRAM responder: byte-enabled synchronous write, registered read.
module sdram_resp_mem
    import sdram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic [1:0]                wr_be,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DQ_WIDTH-1:0]       wr_data,
    output logic [DQ_WIDTH-1:0]       rd_data
);

    logic [DQ_WIDTH-1:0] mem [1 << MEM_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_be[0]) mem[mem_addr][7:0]  <= wr_data[7:0];
        if (wr_be[1]) mem[mem_addr][15:8] <= wr_data[15:8];
        rd_data <= mem[mem_addr];
    end

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM emulator: decodes the command bus, enforces init/timing rules, serves reads/writes.
// state  | meaning
// W_PALL | after reset, waiting for precharge-all
// W_REF1 | waiting for first auto-refresh
// W_REF2 | waiting for second auto-refresh
// W_MRS  | waiting for a valid mode register set
// READY  | initialised, normal traffic accepted
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 9,
    parameter int BANK_WIDTH     = 2,
    parameter int SDRADDR_WIDTH  = 13,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int TRCD           = 2,
    parameter int TRFC           = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clock_enable,
    input  logic                     cs_n,
    input  logic                     ras_n,
    input  logic                     cas_n,
    input  logic                     we_n,
    input  logic [BANK_WIDTH-1:0]    bank_addr,
    input  logic [SDRADDR_WIDTH-1:0] addr,
    input  logic                     data_mask_low,
    input  logic                     data_mask_high,
    input  logic [DQ_WIDTH-1:0]      dq_in,
    output logic [DQ_WIDTH-1:0]      dq_out,
    output logic [1:0]               dq_oe,
    output logic                     init_done,
    output logic                     err,
    output logic [2:0]               err_code
);

    localparam int NBANK = 1 << BANK_WIDTH;
    localparam int AGE_W = $clog2(TRCD + 1);
    localparam int RFC_W = $clog2(TRFC + 1);

    init_state_t             state, state_nxt;
    sdram_cmd_t              cmd;
    sdram_err_t              viol_code;
    logic                    a10, mrs_ok, accept, viol;
    logic [2:0]              mrs_cl, cl_q;
    logic [NBANK-1:0]        bank_open;
    logic [ROW_WIDTH-1:0]    open_row [NBANK];
    logic [AGE_W-1:0]        bank_age [NBANK];
    logic [RFC_W-1:0]        rfc_cnt;
    logic [1:0]              wr_be;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DQ_WIDTH-1:0]     mem_rdata;

    logic                    rd_req, rd_cl2, hold_vld;
    logic [1:0]              rd_oe, hold_oe;
    logic [DQ_WIDTH-1:0]     hold_data;

    assign cmd       = (clock_enable && !cs_n) ? sdram_cmd_t'({ras_n, cas_n, we_n}) : CMD_NOP;
    assign a10       = addr[AP_BIT];
    assign mrs_cl    = addr[MRS_CL_MSB:MRS_CL_LSB];
    assign mrs_ok    = cl_legal(mrs_cl) && (addr[MRS_BL_MSB:0] == '0);
    assign init_done = (state == READY);

    // Linear index truncated to the store depth; rows/banks above it alias on purpose.
    assign mem_addr = MEM_ADDR_WIDTH'({bank_addr, open_row[bank_addr], addr[COL_WIDTH-1:0]});
    assign wr_be    = (accept && cmd == CMD_WRITE) ? ~{data_mask_high, data_mask_low} : 2'b00;

    sdram_resp_mem #(.MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_mem (
        .clk      (clk),
        .wr_be    (wr_be),
        .mem_addr (mem_addr),
        .wr_data  (dq_in),
        .rd_data  (mem_rdata)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        viol      = 1'b0;
        viol_code = ERR_NONE;
        if (state != READY) begin
            if (cmd != CMD_NOP) begin
                viol      = 1'b1;
                viol_code = ERR_INIT;
                case (state)
                    W_PALL: if (cmd == CMD_PRE && a10) begin
                        viol = 1'b0; accept = 1'b1; state_nxt = W_REF1;
                    end
                    W_REF1: if (cmd == CMD_REF) begin
                        viol = 1'b0; accept = 1'b1; state_nxt = W_REF2;
                    end
                    W_REF2: if (cmd == CMD_REF) begin
                        viol = 1'b0; accept = 1'b1; state_nxt = W_MRS;
                    end
                    W_MRS: if (cmd == CMD_MRS) begin
                        viol_code = ERR_MRS;
                        if (mrs_ok) begin
                            viol = 1'b0; accept = 1'b1; state_nxt = READY;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (cmd != CMD_NOP) begin
            if (rfc_cnt != '0) begin
                viol      = 1'b1;
                viol_code = ERR_TRFC;
            end else begin
                case (cmd)
                    CMD_ACT: begin
                        if (bank_open[bank_addr]) begin
                            viol = 1'b1; viol_code = ERR_ACT_OPEN;
                        end else accept = 1'b1;
                    end
                    CMD_READ, CMD_WRITE: begin
                        if (!bank_open[bank_addr]) begin
                            viol = 1'b1; viol_code = ERR_CLOSED;
                        end else if (bank_age[bank_addr] < AGE_W'(TRCD)) begin
                            viol = 1'b1; viol_code = ERR_TRCD;
                        end else accept = 1'b1;
                    end
                    CMD_PRE: accept = 1'b1;
                    CMD_REF: begin
                        if (|bank_open) begin
                            viol = 1'b1; viol_code = ERR_REF_OPEN;
                        end else accept = 1'b1;
                    end
                    CMD_MRS: begin
                        if (mrs_ok) accept = 1'b1;
                        else begin
                            viol = 1'b1; viol_code = ERR_MRS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= W_PALL;
            bank_open <= '0;
            cl_q      <= CL_3;
            rfc_cnt   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            rd_req    <= 1'b0;
            rd_cl2    <= 1'b0;
            rd_oe     <= 2'b00;
            hold_vld  <= 1'b0;
            hold_oe   <= 2'b00;
            hold_data <= '0;
            dq_out    <= '0;
            dq_oe     <= 2'b00;
            for (int b = 0; b < NBANK; b++) begin
                open_row[b] <= '0;
                bank_age[b] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (viol && !err) begin
                err      <= 1'b1;
                err_code <= viol_code;
            end

            if (accept && cmd == CMD_REF) rfc_cnt <= RFC_W'(TRFC);
            else if (rfc_cnt != '0)       rfc_cnt <= rfc_cnt - RFC_W'(1);

            if (accept && cmd == CMD_MRS) cl_q <= mrs_cl;

            for (int b = 0; b < NBANK; b++) begin
                if (accept && cmd == CMD_ACT && bank_addr == BANK_WIDTH'(b)) begin
                    bank_open[b] <= 1'b1;
                    open_row[b]  <= addr[ROW_WIDTH-1:0];
                    bank_age[b]  <= AGE_W'(1);
                end else if (bank_age[b] < AGE_W'(TRCD)) begin
                    bank_age[b] <= bank_age[b] + AGE_W'(1);
                end
            end

            if (accept) begin
                case (cmd)
                    CMD_PRE: begin
                        if (a10) bank_open <= '0;
                        else     bank_open[bank_addr] <= 1'b0;
                    end
                    CMD_READ, CMD_WRITE: if (a10) bank_open[bank_addr] <= 1'b0;
                    default: ;
                endcase
            end

            // CL latched per read so an MRS only affects later reads.
            rd_req    <= accept && cmd == CMD_READ;
            rd_oe     <= ~{data_mask_high, data_mask_low};
            rd_cl2    <= (cl_q == CL_2);
            hold_vld  <= rd_req && !rd_cl2;
            hold_data <= mem_rdata;
            hold_oe   <= rd_oe;
            if (hold_vld) begin
                dq_out <= hold_data;
                dq_oe  <= hold_oe;
            end else if (rd_req && rd_cl2) begin
                dq_out <= mem_rdata;
                dq_oe  <= rd_oe;
            end else begin
                dq_out <= '0;
                dq_oe  <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_sdram_responder;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_READ = 3'b101, C_WRITE = 3'b100,
                           C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n, clock_enable, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  bank_addr;
    logic [12:0] addr;
    logic        data_mask_low, data_mask_high;
    logic [15:0] dq_in, dq_out;
    logic [1:0]  dq_oe;
    logic        init_done, err;
    logic [2:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] mdl [4096];
    int model_cl;

    always #5 clk = ~clk;

    sdram_responder dut (
        .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable), .cs_n(cs_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bank_addr(bank_addr), .addr(addr),
        .data_mask_low(data_mask_low), .data_mask_high(data_mask_high), .dq_in(dq_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .init_done(init_done), .err(err), .err_code(err_code)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lin_idx(input int bank, input int row, input int col);
        return (bank * (1 << 22) + row * (1 << 9) + col) % 4096;
    endfunction

    task automatic issue(input logic [2:0] c, input int bank, input int a, input logic [15:0] d,
                         input logic mh, input logic ml);
        clock_enable = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = c;
        bank_addr = 2'(bank); addr = 13'(a); dq_in = d;
        data_mask_high = mh; data_mask_low = ml;
        @(posedge clk); #1;
        cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
        data_mask_high = 1'b0; data_mask_low = 1'b0;
    endtask

    task automatic nops(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic act(input int bank, input int row);
        issue(C_ACT, bank, row, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clock_enable = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
        bank_addr = 2'b00; addr = '0; dq_in = '0; data_mask_low = 1'b0; data_mask_high = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_cl = 3;
    endtask

    task automatic do_init();
        issue(C_PRE, 0, 1 << 10, 16'h0, 1'b0, 1'b0);
        issue(C_REF, 0, 0, 16'h0, 1'b0, 1'b0);
        nops(7);
        issue(C_REF, 0, 0, 16'h0, 1'b0, 1'b0);
        nops(7);
        issue(C_MRS, 0, 'h230, 16'h0, 1'b0, 1'b0);
        model_cl = 3;
    endtask

    task automatic model_write(input int idx, input logic [15:0] d, input logic mh, input logic ml);
        if (!ml) mdl[idx][7:0]  = d[7:0];
        if (!mh) mdl[idx][15:8] = d[15:8];
    endtask

    // Issues a READ and watches what the controller would sample at edges E+1..E+5.
    task automatic read_obs(input int bank, input int col, input logic mh, input logic ml, input int ap,
                            output logic [15:0] d, output logic [1:0] oe, output int lat, output int nvld);
        issue(C_READ, bank, (ap << 10) | col, 16'h0, mh, ml);
        lat = -1; nvld = 0; d = '0; oe = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (dq_oe !== 2'b00) begin
                if (lat < 0) begin lat = k; d = dq_out; oe = dq_oe; end
                nvld++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL reset_dq_oe: got %b exp 00", dq_oe); end
        n_tests++; if (dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_dq_out: got %h exp 0000", dq_out); end
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b exp 0", init_done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err); end
        n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d exp 0", err_code); end
    endtask

    task automatic test_init();
        issue(C_PRE, 0, 1 << 10, 16'h0, 1'b0, 1'b0);
        issue(C_REF, 0, 0, 16'h0, 1'b0, 1'b0);
        nops(7);
        issue(C_REF, 0, 0, 16'h0, 1'b0, 1'b0);
        nops(7);
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_before_mrs: got %b exp 0", init_done); end
        issue(C_MRS, 0, 'h230, 16'h0, 1'b0, 1'b0);
        model_cl = 3;
        n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b exp 1", init_done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL init_err: got %b exp 0", err); end
    endtask

    task automatic test_write_read();
        logic [15:0] d; logic [1:0] oe; int lat, nv, idx;
        idx = lin_idx(1, 5, 'h12);
        act(1, 5); nops(2);
        issue(C_WRITE, 1, (1 << 10) | 'h12, 16'hBEEF, 1'b0, 1'b0);
        model_write(idx, 16'hBEEF, 1'b0, 1'b0);
        act(1, 5); nops(2);
        read_obs(1, 'h12, 1'b0, 1'b0, 1, d, oe, lat, nv);
        n_tests++; if (lat !== model_cl) begin n_fail++; $display("FAIL wr_rd_latency: got %0d exp %0d", lat, model_cl); end
        n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL wr_rd_valid_cycles: got %0d exp 1", nv); end
        n_tests++; if (d !== mdl[idx]) begin n_fail++; $display("FAIL wr_rd_data: got %h exp %h", d, mdl[idx]); end
        n_tests++; if (oe !== 2'b11) begin n_fail++; $display("FAIL wr_rd_oe: got %b exp 11", oe); end
    endtask

    task automatic test_byte_mask();
        logic [15:0] d; logic [1:0] oe; int lat, nv, idx;
        idx = lin_idx(1, 5, 'h12);
        act(1, 5); nops(2);
        issue(C_WRITE, 1, (1 << 10) | 'h12, 16'h1234, 1'b1, 1'b0);
        model_write(idx, 16'h1234, 1'b1, 1'b0);
        act(1, 5); nops(2);
        read_obs(1, 'h12, 1'b0, 1'b0, 1, d, oe, lat, nv);
        n_tests++; if (d !== mdl[idx]) begin n_fail++; $display("FAIL mask_merge_data: got %h exp %h", d, mdl[idx]); end
        act(1, 5); nops(2);
        read_obs(1, 'h12, 1'b0, 1'b1, 1, d, oe, lat, nv);
        n_tests++; if (oe !== 2'b10) begin n_fail++; $display("FAIL mask_read_oe: got %b exp 10", oe); end
        n_tests++; if (d !== mdl[idx]) begin n_fail++; $display("FAIL mask_read_data: got %h exp %h", d, mdl[idx]); end
    endtask

    task automatic test_closed_bank();
        logic [15:0] d; logic [1:0] oe; int lat, nv, idx;
        read_obs(2, 0, 1'b0, 1'b0, 0, d, oe, lat, nv);
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL closed_no_data: got %0d valid cycles exp 0", nv); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL closed_err: got %b exp 1", err); end
        n_tests++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL closed_err_code: got %0d exp 3", err_code); end
        idx = lin_idx(1, 5, 'h12);
        act(1, 5);
        act(1, 5);
        nops(1);
        read_obs(1, 'h12, 1'b0, 1'b0, 1, d, oe, lat, nv);
        n_tests++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL first_err_kept: got %0d exp 3", err_code); end
        n_tests++; if (d !== mdl[idx] || lat !== model_cl) begin
            n_fail++; $display("FAIL after_err_read: got %h lat %0d exp %h lat %0d", d, lat, mdl[idx], model_cl);
        end
    endtask

    task automatic test_trcd();
        logic [15:0] d; logic [1:0] oe; int lat, nv;
        do_reset(); do_init();
        act(0, 0);
        read_obs(0, 0, 1'b0, 1'b0, 0, d, oe, lat, nv);
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL trcd_no_data: got %0d valid cycles exp 0", nv); end
        n_tests++; if (err_code !== 3'd6 || err !== 1'b1) begin
            n_fail++; $display("FAIL trcd_err_code: got err %b code %0d exp err 1 code 6", err, err_code);
        end
    endtask

    task automatic test_trfc();
        do_reset(); do_init();
        issue(C_REF, 0, 0, 16'h0, 1'b0, 1'b0);
        nops(7);
        act(0, 7);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL trfc_boundary_ok: got err %b code %0d exp 0", err, err_code); end
        issue(C_PRE, 0, 0, 16'h0, 1'b0, 1'b0);
        issue(C_REF, 0, 0, 16'h0, 1'b0, 1'b0);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ref_after_pre: got err %b code %0d exp 0", err, err_code); end
        nops(2);
        act(0, 7);
        n_tests++; if (err_code !== 3'd7 || err !== 1'b1) begin
            n_fail++; $display("FAIL trfc_err_code: got err %b code %0d exp err 1 code 7", err, err_code);
        end
    endtask

    task automatic test_mrs_err();
        logic [15:0] d; logic [1:0] oe; int lat, nv, idx;
        do_reset(); do_init();
        issue(C_MRS, 0, 'h250, 16'h0, 1'b0, 1'b0);
        n_tests++; if (err_code !== 3'd5) begin n_fail++; $display("FAIL mrs_bad_cl: got %0d exp 5", err_code); end
        idx = lin_idx(0, 9, 3);
        act(0, 9); nops(2);
        issue(C_WRITE, 0, (1 << 10) | 3, 16'h5A0F, 1'b0, 1'b0);
        model_write(idx, 16'h5A0F, 1'b0, 1'b0);
        act(0, 9); nops(2);
        read_obs(0, 3, 1'b0, 1'b0, 1, d, oe, lat, nv);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL mrs_bad_keeps_cl: got lat %0d exp 3", lat); end
        do_reset(); do_init();
        issue(C_MRS, 0, 'h231, 16'h0, 1'b0, 1'b0);
        n_tests++; if (err_code !== 3'd5) begin n_fail++; $display("FAIL mrs_bad_bl: got %0d exp 5", err_code); end
    endtask

    task automatic test_random();
        int eb[12], er[12], ec[12];
        int op, j, cl, idx, lat, nv;
        logic [15:0] d, got_d;
        logic [1:0] m, got_oe;
        do_reset(); do_init();
        for (int i = 0; i < 12; i++) begin
            eb[i] = $urandom_range(0, 3); er[i] = $urandom_range(0, 8191); ec[i] = $urandom_range(0, 511);
            d = 16'($urandom);
            act(eb[i], er[i]); nops($urandom_range(1, 3));
            issue(C_WRITE, eb[i], (1 << 10) | ec[i], d, 1'b0, 1'b0);
            model_write(lin_idx(eb[i], er[i], ec[i]), d, 1'b0, 1'b0);
        end
        for (int n = 0; n < 60; n++) begin
            op  = $urandom_range(0, 9);
            j   = $urandom_range(0, 11);
            idx = lin_idx(eb[j], er[j], ec[j]);
            if (op == 0) begin
                issue(C_REF, 0, 0, 16'h0, 1'b0, 1'b0);
                nops(7);
            end else if (op == 1) begin
                cl = $urandom_range(2, 3);
                issue(C_MRS, 0, cl << 4, 16'h0, 1'b0, 1'b0);
                model_cl = cl;
            end else if (op < 5) begin
                d = 16'($urandom); m = 2'($urandom);
                act(eb[j], er[j]); nops($urandom_range(1, 3));
                issue(C_WRITE, eb[j], (1 << 10) | ec[j], d, m[1], m[0]);
                model_write(idx, d, m[1], m[0]);
            end else begin
                m = 2'($urandom_range(0, 2));
                act(eb[j], er[j]); nops($urandom_range(1, 3));
                read_obs(eb[j], ec[j], m[1], m[0], 1, got_d, got_oe, lat, nv);
                n_tests++; if (lat !== model_cl) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", n, lat, model_cl); end
                n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL rand_valid_cycles[%0d]: got %0d exp 1", n, nv); end
                n_tests++; if (got_oe !== ~m) begin n_fail++; $display("FAIL rand_oe[%0d]: got %b exp %b", n, got_oe, ~m); end
                n_tests++; if (got_d !== mdl[idx]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h exp %h", n, got_d, mdl[idx]); end
            end
        end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_no_err: got err %b code %0d exp 0", err, err_code); end
    endtask

    task automatic test_cl2_reset();
        logic [15:0] d; logic [1:0] oe; int lat, nv, idx;
        do_reset(); do_init();
        issue(C_MRS, 0, 'h220, 16'h0, 1'b0, 1'b0);
        model_cl = 2;
        idx = lin_idx(3, 100, 5);
        act(3, 100); nops(2);
        issue(C_WRITE, 3, (1 << 10) | 5, 16'hA5C3, 1'b0, 1'b0);
        model_write(idx, 16'hA5C3, 1'b0, 1'b0);
        act(3, 100); nops(1);
        read_obs(3, 5, 1'b0, 1'b0, 1, d, oe, lat, nv);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL cl2_latency: got %0d exp 2", lat); end
        n_tests++; if (d !== mdl[idx]) begin n_fail++; $display("FAIL cl2_data: got %h exp %h", d, mdl[idx]); end
        act(3, 100); nops(2);
        issue(C_READ, 3, 5, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            n_tests++; if (dq_oe !== 2'b00) begin n_fail++; $display("FAIL reset_flush_oe[E+%0d]: got %b exp 00", k, dq_oe); end
        end
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_clears_init: got %b exp 0", init_done); end
        @(posedge clk); #1 rst_n = 1'b1;
        model_cl = 3;
    endtask

    task automatic test_init_err();
        do_reset();
        act(0, 0);
        n_tests++; if (err_code !== 3'd1 || err !== 1'b1) begin
            n_fail++; $display("FAIL init_err_code: got err %b code %0d exp err 1 code 1", err, err_code);
        end
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_err_no_advance: got %b exp 0", init_done); end
        do_init();
        n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_after_err: got %b exp 1", init_done); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_mask();
        test_closed_bank();
        test_trcd();
        test_trfc();
        test_mrs_err();
        test_random();
        test_cl2_reset();
        test_init_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
